// File: rtl/box_anim_ctrl_if.sv
// Handshake bundle between the box animation controller and its host/draw engine.
// The master modport is the controller side; the slave modport is the engine/host side.
interface box_anim_ctrl_if;
  logic       iEnable;
  logic [2:0] iColour;
  logic       iDrawDone;
  logic       oReq;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [2:0] oColour;
  logic       oBusy;

  modport master (
    input  iEnable,
    input  iColour,
    input  iDrawDone,
    output oReq,
    output oX,
    output oY,
    output oColour,
    output oBusy
  );

  modport slave (
    output iEnable,
    output iColour,
    output iDrawDone,
    input  oReq,
    input  oX,
    input  oY,
    input  oColour,
    input  oBusy
  );
endinterface

// File: rtl/box_anim_ctrl.sv
// Bouncing-box animator: draw box, rest FRAMES_PER_MOVE frames, erase, step one pixel, repeat.
// Latency: request one cycle after enable or after MOVE; oReq drops the cycle after iDrawDone.
// Backpressure: oReq and its payload hold until iDrawDone; iDrawDone without oReq is ignored.
module box_anim_ctrl #(
  parameter int X_SCREEN_PIXELS  = 160,
  parameter int Y_SCREEN_PIXELS  = 120,
  parameter int BOX_SIZE         = 4,
  parameter int CYCLES_PER_FRAME = 833334,
  parameter int FRAMES_PER_MOVE  = 4
) (
  input  logic            iClock,
  input  logic            iReset,
  box_anim_ctrl_if.master bus
);

  localparam int         XMAX   = X_SCREEN_PIXELS - BOX_SIZE;
  localparam int         YMAX   = Y_SCREEN_PIXELS - BOX_SIZE;
  localparam logic [7:0] XMAX_V = 8'(XMAX);
  localparam logic [6:0] YMAX_V = 7'(YMAX);
  localparam int         CW     = (CYCLES_PER_FRAME > 1) ? $clog2(CYCLES_PER_FRAME) : 1;
  localparam int         FW     = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_FRAME - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(FRAMES_PER_MOVE - 1);

  typedef enum logic [2:0] {
    IDLE,
    DRAW_REQ,
    WAIT_FRAME,
    ERASE_REQ,
    MOVE
  } state_t;

  state_t        state;
  logic [7:0]    pos_x;
  logic [6:0]    pos_y;
  logic          dx_pos;
  logic          dy_pos;
  logic [2:0]    draw_col;
  logic [CW-1:0] cyc_cnt;
  logic [FW-1:0] frm_cnt;

  logic [7:0]    nxt_x;
  logic [6:0]    nxt_y;
  logic          nxt_dx_pos;
  logic          nxt_dy_pos;

  // Next position with edge reflection: hitting a wall turns the box around
  // and moves it one pixel back inside in the same step.
  always_comb begin
    nxt_x      = pos_x;
    nxt_dx_pos = dx_pos;
    if (dx_pos) begin
      if (pos_x == XMAX_V) begin
        nxt_dx_pos = 1'b0;
        nxt_x      = XMAX_V - 8'd1;
      end else begin
        nxt_x      = pos_x + 8'd1;
      end
    end else begin
      if (pos_x == 8'd0) begin
        nxt_dx_pos = 1'b1;
        nxt_x      = 8'd1;
      end else begin
        nxt_x      = pos_x - 8'd1;
      end
    end
  end

  always_comb begin
    nxt_y      = pos_y;
    nxt_dy_pos = dy_pos;
    if (dy_pos) begin
      if (pos_y == YMAX_V) begin
        nxt_dy_pos = 1'b0;
        nxt_y      = YMAX_V - 7'd1;
      end else begin
        nxt_y      = pos_y + 7'd1;
      end
    end else begin
      if (pos_y == 7'd0) begin
        nxt_dy_pos = 1'b1;
        nxt_y      = 7'd1;
      end else begin
        nxt_y      = pos_y - 7'd1;
      end
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state       <= IDLE;
      pos_x       <= 8'd0;
      pos_y       <= 7'd0;
      dx_pos      <= 1'b1;
      dy_pos      <= 1'b1;
      draw_col    <= 3'd0;
      cyc_cnt     <= '0;
      frm_cnt     <= '0;
      bus.oReq    <= 1'b0;
      bus.oX      <= 8'd0;
      bus.oY      <= 7'd0;
      bus.oColour <= 3'd0;
      bus.oBusy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Restart draws at the retained position; the box is still on screen.
          if (bus.iEnable) begin
            state       <= DRAW_REQ;
            draw_col    <= bus.iColour;
            bus.oReq    <= 1'b1;
            bus.oX      <= pos_x;
            bus.oY      <= pos_y;
            bus.oColour <= bus.iColour;
            bus.oBusy   <= 1'b1;
          end
        end

        DRAW_REQ: begin
          if (bus.iDrawDone) begin
            state    <= WAIT_FRAME;
            bus.oReq <= 1'b0;
            cyc_cnt  <= '0;
            frm_cnt  <= '0;
          end
        end

        WAIT_FRAME: begin
          if (!bus.iEnable) begin
            state     <= IDLE;
            bus.oBusy <= 1'b0;
          end else if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            if (frm_cnt == FRM_LAST) begin
              frm_cnt     <= '0;
              state       <= ERASE_REQ;
              bus.oReq    <= 1'b1;
              bus.oX      <= pos_x;
              bus.oY      <= pos_y;
              bus.oColour <= 3'd0;
            end else begin
              frm_cnt <= frm_cnt + 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        ERASE_REQ: begin
          if (bus.iDrawDone) begin
            state    <= MOVE;
            bus.oReq <= 1'b0;
          end
        end

        MOVE: begin
          state       <= DRAW_REQ;
          pos_x       <= nxt_x;
          pos_y       <= nxt_y;
          dx_pos      <= nxt_dx_pos;
          dy_pos      <= nxt_dy_pos;
          draw_col    <= bus.iColour;
          bus.oReq    <= 1'b1;
          bus.oX      <= nxt_x;
          bus.oY      <= nxt_y;
          bus.oColour <= bus.iColour;
        end

        default: begin
          state       <= IDLE;
          bus.oReq    <= 1'b0;
          bus.oBusy   <= 1'b0;
        end
      endcase
    end
  end

  // draw_col mirrors oColour during draws; kept as the colour of record for the box.
  logic unused_draw_col;
  assign unused_draw_col = ^draw_col;

endmodule

// File: tb/tb_box_anim_ctrl.sv
// Directed bench for box_anim_ctrl on a tiny 8x6 screen with 4-cycle frames and 2-frame rests.
module tb_box_anim_ctrl;

  logic iClock = 1'b0;
  logic iReset = 1'b0;
  box_anim_ctrl_if bus();

  box_anim_ctrl #(
    .X_SCREEN_PIXELS (8),
    .Y_SCREEN_PIXELS (6),
    .BOX_SIZE        (4),
    .CYCLES_PER_FRAME(4),
    .FRAMES_PER_MOVE (2)
  ) dut (
    .iClock(iClock),
    .iReset(iReset),
    .bus   (bus)
  );

  always #5 iClock = ~iClock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic wait_req(input int max, output int n);
    n = 0;
    while (bus.oReq !== 1'b1 && n < max) begin
      step();
      n++;
    end
    if (bus.oReq !== 1'b1) check("req_timeout", 32'(bus.oReq), 32'd1);
  endtask

  task automatic finish_op();
    bus.iDrawDone = 1'b1;
    step();
    bus.iDrawDone = 1'b0;
  endtask

  // From an outstanding draw at (px,py): optional hold cycles, done, rest, erase, move, next draw.
  task automatic bounce_cycle(input int hold, input bit spur, input int px, input int py,
                              input int ex, input int ey, input int col);
    int n;
    int extra;
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_req", 32'(bus.oReq), 32'd1);
      check("hold_x", 32'(bus.oX), 32'(px));
    end
    finish_op();
    check("draw_drop", 32'(bus.oReq), 32'd0);
    extra = 0;
    if (spur) begin
      step();
      bus.iDrawDone = 1'b1;
      step();
      bus.iDrawDone = 1'b0;
      check("spur_req", 32'(bus.oReq), 32'd0);
      check("spur_busy", 32'(bus.oBusy), 32'd1);
      extra = 2;
    end
    wait_req(30, n);
    check("rest_len", 32'(n + extra), 32'd8);
    check("erase_col", 32'(bus.oColour), 32'd0);
    check("erase_x", 32'(bus.oX), 32'(px));
    check("erase_y", 32'(bus.oY), 32'(py));
    finish_op();
    check("move_req", 32'(bus.oReq), 32'd0);
    check("move_busy", 32'(bus.oBusy), 32'd1);
    step();
    check("draw_req", 32'(bus.oReq), 32'd1);
    check("draw_x", 32'(bus.oX), 32'(ex));
    check("draw_y", 32'(bus.oY), 32'(ey));
    check("draw_col", 32'(bus.oColour), 32'(col));
  endtask

  int ex_tab[8] = '{2, 3, 4, 3, 2, 1, 0, 1};
  int ey_tab[8] = '{2, 1, 0, 1, 2, 1, 0, 1};

  initial begin
    int px;
    int py;
    bus.iEnable   = 1'b0;
    bus.iColour   = 3'd0;
    bus.iDrawDone = 1'b0;

    // Asynchronous reset before any clock edge.
    #2;
    iReset = 1'b1;
    #1;
    check("rst_req", 32'(bus.oReq), 32'd0);
    check("rst_x", 32'(bus.oX), 32'd0);
    check("rst_y", 32'(bus.oY), 32'd0);
    check("rst_col", 32'(bus.oColour), 32'd0);
    check("rst_busy", 32'(bus.oBusy), 32'd0);
    step();
    step();
    iReset = 1'b0;
    step();
    check("idle_busy", 32'(bus.oBusy), 32'd0);

    // First handshake with a late done, then erase and the first move.
    bus.iEnable = 1'b1;
    bus.iColour = 3'd5;
    step();
    check("first_req", 32'(bus.oReq), 32'd1);
    check("first_x", 32'(bus.oX), 32'd0);
    check("first_y", 32'(bus.oY), 32'd0);
    check("first_col", 32'(bus.oColour), 32'd5);
    check("first_busy", 32'(bus.oBusy), 32'd1);
    bounce_cycle(2, 1'b0, 0, 0, 1, 1, 5);

    // Bounce around the 5x3 position space; colour re-latched on each move.
    bus.iColour = 3'd3;
    px = 1;
    py = 1;
    for (int i = 0; i < 8; i++) begin
      bounce_cycle(0, (i == 3), px, py, ex_tab[i], ey_tab[i], 3);
      px = ex_tab[i];
      py = ey_tab[i];
    end

    // Disable during a draw: draw completes, one rest cycle, then idle.
    bus.iEnable = 1'b0;
    step();
    check("dis_noabort", 32'(bus.oReq), 32'd1);
    finish_op();
    check("dis_wait_req", 32'(bus.oReq), 32'd0);
    check("dis_wait_busy", 32'(bus.oBusy), 32'd1);
    step();
    check("dis_idle_busy", 32'(bus.oBusy), 32'd0);
    step();
    step();
    check("dis_idle_req", 32'(bus.oReq), 32'd0);
    bus.iColour = 3'd6;
    bus.iEnable = 1'b1;
    step();
    check("reen_req", 32'(bus.oReq), 32'd1);
    check("reen_x", 32'(bus.oX), 32'd1);
    check("reen_y", 32'(bus.oY), 32'd1);
    check("reen_col", 32'(bus.oColour), 32'd6);

    // Reset mid-handshake between clock edges.
    #2;
    iReset = 1'b1;
    #1;
    check("abort_req", 32'(bus.oReq), 32'd0);
    check("abort_busy", 32'(bus.oBusy), 32'd0);
    check("abort_x", 32'(bus.oX), 32'd0);
    check("abort_col", 32'(bus.oColour), 32'd0);
    bus.iEnable = 1'b0;
    step();
    iReset = 1'b0;
    step();
    bus.iDrawDone = 1'b1;
    step();
    bus.iDrawDone = 1'b0;
    check("late_done_req", 32'(bus.oReq), 32'd0);
    check("late_done_busy", 32'(bus.oBusy), 32'd0);
    bus.iColour = 3'd2;
    bus.iEnable = 1'b1;
    step();
    check("post_rst_req", 32'(bus.oReq), 32'd1);
    check("post_rst_x", 32'(bus.oX), 32'd0);
    check("post_rst_y", 32'(bus.oY), 32'd0);
    check("post_rst_col", 32'(bus.oColour), 32'd2);
    bounce_cycle(0, 1'b0, 0, 0, 1, 1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
